// File: rtl/flopr_skid.sv
// flopr_skid: ready/valid pipeline register, one cycle latency, synchronous flush.
// Define FLOPR_SKID_PIPE_SKID_EN for the two-entry skid buffer with registered in_ready.
module flopr_skid #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // Handshake: a word moves across a side when valid and ready are both high at a
  // rising clk edge; valid never depends on ready, and a producer holds its word until taken.

  // State encoding equals the number of held words, so occupancy is the state view.
`ifdef FLOPR_SKID_PIPE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef FLOPR_SKID_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q;

  assign in_ready = ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A squash wins over any capture; main keeps whatever it last showed.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != TWO);
    end
  end
`else
  // Without a skid entry, space frees up in the same cycle the consumer takes main.
  assign in_ready = ~reset & (~out_valid | out_ready);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif

endmodule

// File: tb/tb_flopr_skid.sv
// Testbench for flopr_skid: scenario tasks plus a randomized run against a queue model.
// Follows FLOPR_SKID_PIPE_SKID_EN to pick the expected capacity (2 with skid, else 1).
module tb_flopr_skid;
  localparam int               W  = 8;
  localparam logic [W-1:0]     RV = 8'hA5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  always #5 clk = ~clk;

  flopr_skid #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // Reference model: the words held, oldest first, plus the word shown when empty.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] shown;
  int checks = 0;
  int failures = 0;

  logic         o_ready, o_valid, e_ready, e_valid;
  logic [1:0]   o_occ, e_occ;
  logic [W-1:0] o_data, e_data;

  task automatic model_reset();
    exp_q.delete();
    shown = RV;
  endtask

  // One clock cycle: drive inputs, sample DUT and model before the edge, advance model.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic r,
                             input logic f, output logic acc);
    logic in_fire, out_fire;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(negedge clk);
    o_ready = in_ready; o_valid = out_valid; o_occ = occupancy; o_data = out_data;
    e_valid = (exp_q.size() > 0);
    e_data  = e_valid ? exp_q[0] : shown;
    e_occ   = 2'(exp_q.size());
`ifdef FLOPR_SKID_PIPE_SKID_EN
    e_ready = (exp_q.size() < 2);
`else
    e_ready = (exp_q.size() == 0) || r;
`endif
    in_fire  = v && e_ready;
    out_fire = e_valid && r;
    acc = in_fire && !f;
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      if (out_fire) void'(exp_q.pop_front());
      if (in_fire) exp_q.push_back(d);
    end
    if (exp_q.size() > 0) shown = exp_q[0];
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; flush = 0; out_ready = 0;
    @(posedge clk); #2;
    reset = 1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== RV) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, RV); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    #1 reset = 0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL post_reset_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stream();
    logic acc;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i < 4, W'((i + 1) * 4), 1'b1, 1'b0, acc);
      checks++;
      if ({o_ready, o_valid, o_occ, o_data} !== {e_ready, e_valid, e_occ, e_data}) begin
        failures++;
        $display("FAIL stream cyc=%0d got rdy=%b vld=%b occ=%0d data=%0d exp rdy=%b vld=%b occ=%0d data=%0d",
                 i, o_ready, o_valid, o_occ, o_data, e_ready, e_valid, e_occ, e_data);
      end
      if (i < 4) begin
        checks++;
        if (acc !== 1'b1) begin failures++; $display("FAIL stream_accept cyc=%0d got=%b exp=1", i, acc); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] words [3];
    logic acc;
    int idx = 0;
    words[0] = 8'd4; words[1] = 8'd8; words[2] = 8'd12;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(idx < 3, words[idx < 3 ? idx : 0], i >= 4, 1'b0, acc);
      checks++;
      if ({o_ready, o_valid, o_occ, o_data} !== {e_ready, e_valid, e_occ, e_data}) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got rdy=%b vld=%b occ=%0d data=%0d exp rdy=%b vld=%b occ=%0d data=%0d",
                 i, o_ready, o_valid, o_occ, o_data, e_ready, e_valid, e_occ, e_data);
      end
      if (acc) idx++;
    end
    checks++;
    if (idx !== 3) begin failures++; $display("FAIL backpressure_all_sent got=%0d exp=3", idx); end
  endtask

  task automatic test_flush();
    logic acc;
    drive_cycle(1'b1, 8'd20, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'd30, 1'b0, 1'b0, acc);
    drive_cycle(1'b1, 8'd111, 1'b0, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 8'd0, 1'b1, 1'b0, acc);
      checks++;
      if ({o_ready, o_valid, o_occ, o_data} !== {e_ready, e_valid, e_occ, e_data}) begin
        failures++;
        $display("FAIL flush cyc=%0d got rdy=%b vld=%b occ=%0d data=%0d exp rdy=%b vld=%b occ=%0d data=%0d",
                 i, o_ready, o_valid, o_occ, o_data, e_ready, e_valid, e_occ, e_data);
      end
      checks++;
      if (o_data === 8'd111 || o_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_squash cyc=%0d got vld=%b data=%0d exp vld=0 data!=111", i, o_valid, o_data);
      end
    end
  endtask

  task automatic test_async_reset();
    logic acc;
    drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0, acc);
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL async_pre_valid got=%b exp=1", out_valid); end
    #2 reset = 1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== RV) begin failures++; $display("FAIL async_out_data got=%h exp=%h", out_data, RV); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL async_occupancy got=%0d exp=0", occupancy); end
    #1 reset = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic acc;
    int max_occ = 0;
    for (int i = 0; i < 400; i++) begin
      drive_cycle(1'($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0), acc);
      if (int'(o_occ) > max_occ) max_occ = int'(o_occ);
      checks++;
      if ({o_ready, o_valid, o_occ, o_data} !== {e_ready, e_valid, e_occ, e_data}) begin
        failures++;
        $display("FAIL random cyc=%0d got rdy=%b vld=%b occ=%0d data=%0d exp rdy=%b vld=%b occ=%0d data=%0d",
                 i, o_ready, o_valid, o_occ, o_data, e_ready, e_valid, e_occ, e_data);
      end
    end
`ifdef FLOPR_SKID_PIPE_SKID_EN
    checks++; if (max_occ > 2) begin failures++; $display("FAIL random_max_occ got=%0d exp<=2", max_occ); end
`else
    checks++; if (max_occ > 1) begin failures++; $display("FAIL random_max_occ got=%0d exp<=1", max_occ); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
